instr_sequencer: RTL and testbench



---
 rtl/instr_sequencer.sv | 153 +++++++++++++++
 tb/tb_instr_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction fetch/issue sequencer feeding the control circuit.
// Fetches 16-bit words from a synchronous ROM, issues one instruction at a
// time and holds it until the control circuit's done handshake retires it.
// LOAD instructions also fetch the following immediate word onto ext_data.
//
// Handshake with the control circuit: done=1 means the control circuit is
// idle. An issued instruction is accepted when done falls (ISSUE -> EXEC),
// and it is retired when done rises again (EXEC -> FETCH). instr is nonzero
// only while an instruction is in ISSUE or EXEC.
module instr_sequencer #(
  parameter int              ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [3:0]      HALT_OP    = 4'hF,
  parameter int              TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic [15:0]       ext_data,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              timeout_err,
  output logic [2:0]        state_dbg
);

  // Opcode encodings shared with the control circuit.
  localparam logic [3:0] INSTR_NOP  = 4'h0;
  localparam logic [3:0] INSTR_LOAD = 4'h1;
  localparam logic [3:0] INSTR_MOV  = 4'h2;
  localparam logic [3:0] INSTR_ADD  = 4'h3;
  localparam logic [3:0] INSTR_XOR  = 4'h4;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_FETCH       = 3'd1,
    S_CAPTURE     = 3'd2,
    S_FETCH_IMM   = 3'd3,
    S_CAPTURE_IMM = 3'd4,
    S_ISSUE       = 3'd5,
    S_EXEC        = 3'd6,
    S_HALTED      = 3'd7
  } state_t;

  state_t           state, state_n;
  logic [15:0]      ir;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       opcode;
  logic             issue_timeout;

  // Opcode of the word arriving from the ROM this cycle (meaningful in CAPTURE).
  assign opcode        = imem_rdata[15:12];
  assign issue_timeout = done && (cnt == CNT_LAST);

  assign imem_addr = pc;
  assign busy      = (state != S_IDLE) && (state != S_HALTED);
  assign halted    = (state == S_HALTED);
  assign state_dbg = state;

  // Next-state decode.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:        if (start) state_n = S_FETCH;
      S_FETCH:       state_n = S_CAPTURE;
      S_CAPTURE: begin
        if (opcode == HALT_OP) begin
          state_n = S_HALTED;
        end else begin
          case (opcode)
            INSTR_NOP:  state_n = S_FETCH;
            INSTR_LOAD: state_n = S_FETCH_IMM;
            INSTR_MOV, INSTR_ADD, INSTR_XOR: state_n = S_ISSUE;
            default:    state_n = S_ISSUE;   // unknown opcodes end in timeout
          endcase
        end
      end
      S_FETCH_IMM:   state_n = S_CAPTURE_IMM;
      S_CAPTURE_IMM: state_n = S_ISSUE;
      S_ISSUE: begin
        if (!done)              state_n = S_EXEC;
        else if (issue_timeout) state_n = S_HALTED;
      end
      S_EXEC:        if (done) state_n = S_FETCH;
      S_HALTED:      if (start) state_n = S_FETCH;
      default:       state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Program counter: steps past NOP, LOAD opcode and retired instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= START_ADDR;
    end else begin
      case (state)
        S_IDLE, S_HALTED: if (start) pc <= START_ADDR;
        S_CAPTURE: if ((opcode != HALT_OP) &&
                       ((opcode == INSTR_NOP) || (opcode == INSTR_LOAD)))
                     pc <= pc + ADDR_W'(1);
        S_EXEC:    if (done) pc <= pc + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  // Instruction register and LOAD immediate capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir       <= '0;
      ext_data <= '0;
    end else begin
      if (state == S_CAPTURE)     ir       <= imem_rdata;
      if (state == S_CAPTURE_IMM) ext_data <= imem_rdata;
    end
  end

  // Registered instr: the issued word while in ISSUE/EXEC, NOP otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= '0;
    end else if ((state_n == S_ISSUE) || (state_n == S_EXEC)) begin
      instr <= (state == S_CAPTURE) ? imem_rdata : ir;
    end else begin
      instr <= '0;
    end
  end

  // ISSUE wait counter and sticky timeout flag (cleared only by restart).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= (state == S_ISSUE) ? cnt + 1'b1 : '0;
      if ((state == S_ISSUE) && issue_timeout) timeout_err <= 1'b1;
      else if ((state == S_HALTED) && start)   timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer: one task per scenario, each with
// its own inline comparisons. Inputs change and outputs are sampled 1 time
// unit after each rising edge.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, done;
  logic [7:0]  imem_addr, pc;
  logic [15:0] imem_rdata, instr, ext_data;
  logic        busy, halted, timeout_err;
  logic [2:0]  state_dbg;

  logic        rst2, start2, done2;
  logic [1:0]  imem_addr2, pc2;
  logic [15:0] imem_rdata2, instr2, ext_data2;
  logic        busy2, halted2, timeout_err2;
  logic [2:0]  state_dbg2;

  logic [15:0] rom  [256];
  logic [15:0] rom2 [4];

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  // synchronous ROM models
  always @(posedge clk) imem_rdata  <= rom[imem_addr];
  always @(posedge clk) imem_rdata2 <= rom2[imem_addr2];

  instr_sequencer #(.ADDR_W(8), .START_ADDR(8'd0), .HALT_OP(4'hF), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr(instr), .ext_data(ext_data), .done(done),
    .pc(pc), .busy(busy), .halted(halted), .timeout_err(timeout_err),
    .state_dbg(state_dbg));

  instr_sequencer #(.ADDR_W(2), .START_ADDR(2'd3), .HALT_OP(4'hF), .TIMEOUT(15)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .instr(instr2), .ext_data(ext_data2), .done(done2),
    .pc(pc2), .busy(busy2), .halted(halted2), .timeout_err(timeout_err2),
    .state_dbg(state_dbg2));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; done = 1'b1;
    rst2 = 1'b1; start2 = 1'b0; done2 = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h expected 0000", instr); end
    checks++; if (pc !== 8'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (imem_addr !== 8'd0) begin errors++; $display("FAIL reset_imem_addr: got %0d expected 0", imem_addr); end
    checks++; if ((timeout_err !== 1'b0) || (ext_data !== 16'h0000)) begin errors++; $display("FAIL reset_err_ext: got %b/%h expected 0/0000", timeout_err, ext_data); end
  endtask

  task automatic test_mov;
    rom[0] = 16'h2120; rom[1] = 16'hF000;
    start = 1'b1; tick(1); start = 1'b0;             // IDLE -> FETCH
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mov_busy: got %b expected 1", busy); end
    tick(1);                                           // FETCH -> CAPTURE
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL mov_not_yet: got %h expected 0000", instr); end
    tick(1);                                           // CAPTURE -> ISSUE
    checks++; if (instr !== 16'h2120) begin errors++; $display("FAIL mov_issue: got %h expected 2120", instr); end
    done = 1'b0; tick(1);                              // ISSUE -> EXEC
    checks++; if (instr !== 16'h2120) begin errors++; $display("FAIL mov_exec1: got %h expected 2120", instr); end
    tick(1);                                           // EXEC holds
    checks++; if (instr !== 16'h2120) begin errors++; $display("FAIL mov_exec2: got %h expected 2120", instr); end
    done = 1'b1; tick(1);                              // retire
    checks++; if ((pc !== 8'd1) || (instr !== 16'h0000)) begin errors++; $display("FAIL mov_retire: got pc=%0d instr=%h expected pc=1 instr=0000", pc, instr); end
    tick(2);                                           // FETCH, CAPTURE HALT
    checks++; if ((halted !== 1'b1) || (pc !== 8'd1) || (instr !== 16'h0000) || (busy !== 1'b0)) begin errors++; $display("FAIL mov_halt: got halted=%b pc=%0d instr=%h busy=%b expected 1/1/0000/0", halted, pc, instr, busy); end
  endtask

  task automatic test_load;
    rom[0] = 16'h1300; rom[1] = 16'hBEEF; rom[2] = 16'hF000;
    start = 1'b1; tick(1); start = 1'b0;             // HALTED -> FETCH, pc=0
    checks++; if (pc !== 8'd0) begin errors++; $display("FAIL load_restart_pc: got %0d expected 0", pc); end
    tick(2);                                           // CAPTURE LOAD -> FETCH_IMM
    checks++; if ((pc !== 8'd1) || (instr !== 16'h0000)) begin errors++; $display("FAIL load_imm_fetch: got pc=%0d instr=%h expected 1/0000", pc, instr); end
    tick(1);                                           // CAPTURE_IMM
    checks++; if ((instr !== 16'h0000) || (ext_data !== 16'h0000)) begin errors++; $display("FAIL load_pre_issue: got instr=%h ext=%h expected 0000/0000", instr, ext_data); end
    tick(1);                                           // ISSUE
    checks++; if ((instr !== 16'h1300) || (ext_data !== 16'hBEEF)) begin errors++; $display("FAIL load_issue: got instr=%h ext=%h expected 1300/beef", instr, ext_data); end
    done = 1'b0; tick(1);
    done = 1'b1; tick(1);                              // retire
    checks++; if ((pc !== 8'd2) || (instr !== 16'h0000)) begin errors++; $display("FAIL load_retire: got pc=%0d instr=%h expected 2/0000", pc, instr); end
    tick(2);
    checks++; if ((halted !== 1'b1) || (pc !== 8'd2) || (ext_data !== 16'hBEEF)) begin errors++; $display("FAIL load_halt: got halted=%b pc=%0d ext=%h expected 1/2/beef", halted, pc, ext_data); end
  endtask

  task automatic test_nop;
    int bad_instr;
    bad_instr = 0;
    rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h0000; rom[3] = 16'hF000;
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (instr !== 16'h0000) bad_instr++;
      tick(1);
    end
    // 8 cycles after start
    checks++; if ((halted !== 1'b0) || (pc !== 8'd3)) begin errors++; $display("FAIL nop_before_halt: got halted=%b pc=%0d expected 0/3", halted, pc); end
    tick(1);
    checks++; if ((halted !== 1'b1) || (pc !== 8'd3)) begin errors++; $display("FAIL nop_halt: got halted=%b pc=%0d expected 1/3", halted, pc); end
    if (instr !== 16'h0000) bad_instr++;
    checks++; if (bad_instr !== 0) begin errors++; $display("FAIL nop_never_issued: got %0d nonzero instr cycles expected 0", bad_instr); end
  endtask

  task automatic test_timeout;
    rom[0] = 16'h2120;
    done = 1'b1;
    start = 1'b1; tick(1); start = 1'b0;
    tick(2);                                           // now in ISSUE
    checks++; if (instr !== 16'h2120) begin errors++; $display("FAIL to_issue: got %h expected 2120", instr); end
    tick(14);                                          // 15th ISSUE cycle
    checks++; if ((halted !== 1'b0) || (timeout_err !== 1'b0) || (instr !== 16'h2120)) begin errors++; $display("FAIL to_early: got halted=%b err=%b instr=%h expected 0/0/2120", halted, timeout_err, instr); end
    tick(1);
    checks++; if ((halted !== 1'b1) || (timeout_err !== 1'b1) || (instr !== 16'h0000)) begin errors++; $display("FAIL to_fire: got halted=%b err=%b instr=%h expected 1/1/0000", halted, timeout_err, instr); end
    tick(3);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
    rom[0] = 16'hF000;
    start = 1'b1; tick(1); start = 1'b0;
    checks++; if ((timeout_err !== 1'b0) || (pc !== 8'd0) || (busy !== 1'b1)) begin errors++; $display("FAIL to_restart: got err=%b pc=%0d busy=%b expected 0/0/1", timeout_err, pc, busy); end
    tick(2);
    checks++; if ((halted !== 1'b1) || (pc !== 8'd0)) begin errors++; $display("FAIL to_rehalt: got halted=%b pc=%0d expected 1/0", halted, pc); end
  endtask

  task automatic test_wrap_and_reset;
    rom2[3] = 16'h1300; rom2[0] = 16'hABCD; rom2[1] = 16'hF000; rom2[2] = 16'hF000;
    rst2 = 1'b0; tick(1);
    checks++; if ((pc2 !== 2'd3) || (busy2 !== 1'b0)) begin errors++; $display("FAIL wrap_reset_pc: got pc=%0d busy=%b expected 3/0", pc2, busy2); end
    start2 = 1'b1; tick(1); start2 = 1'b0;
    tick(2);                                           // LOAD captured, pc wraps
    checks++; if ((pc2 !== 2'd0) || (imem_addr2 !== 2'd0)) begin errors++; $display("FAIL wrap_pc: got pc=%0d addr=%0d expected 0/0", pc2, imem_addr2); end
    tick(2);                                           // ISSUE
    checks++; if ((instr2 !== 16'h1300) || (ext_data2 !== 16'hABCD)) begin errors++; $display("FAIL wrap_issue: got instr=%h ext=%h expected 1300/abcd", instr2, ext_data2); end
    done2 = 1'b0; tick(1);                             // EXEC
    checks++; if ((instr2 !== 16'h1300) || (busy2 !== 1'b1)) begin errors++; $display("FAIL wrap_exec: got instr=%h busy=%b expected 1300/1", instr2, busy2); end
    rst2 = 1'b1; tick(1);                              // reset mid-EXEC
    checks++; if ((instr2 !== 16'h0000) || (busy2 !== 1'b0) || (halted2 !== 1'b0) || (state_dbg2 !== 3'd0)) begin errors++; $display("FAIL mid_reset: got instr=%h busy=%b halted=%b state=%0d expected 0000/0/0/0", instr2, busy2, halted2, state_dbg2); end
    checks++; if ((pc2 !== 2'd3) || (ext_data2 !== 16'h0000)) begin errors++; $display("FAIL mid_reset_regs: got pc=%0d ext=%h expected 3/0000", pc2, ext_data2); end
    rst2 = 1'b0; done2 = 1'b1; tick(1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    test_reset();
    test_mov();
    test_load();
    test_nop();
    test_timeout();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
